monsopc_led_fader: RTL and testbench
====================================

// Module: monsopc_led_fader
// PURPOSE
//  Downstream of the LED PIO: takes its 8-bit out_port and drives the board LEDs.
//  Each LED fades smoothly on or off using a per-channel brightness level and a shared PWM.
//  The LED PIO runs on clk, so led_in is synchronous and needs no synchroniser.
// PARAMETERS
//  NUM_LEDS      8   number of LED channels
//  PWM_BITS      8   PWM counter / brightness width; MAX = 2**PWM_BITS-1
//  CLK_DIV       4   clk cycles per PWM count (>=1; 1 = count every cycle)
//  FADE_PERIODS  2   full PWM periods between brightness updates (>=1)
//  FADE_STEP     8   brightness delta per update (1..MAX)
// PORTS
//  clk       in   1         system clock
//  reset_n   in   1         asynchronous, active-low reset
//  led_in    in   NUM_LEDS  target on/off pattern from the LED PIO out_port
//  enable    in   1         1 = fade/PWM mode, 0 = bypass
//  led_out   out  NUM_LEDS  drive to the physical LEDs (registered)
//  busy      out  1         1 while any channel level differs from its target
// BEHAVIOUR
//  Reset (async, reset_n=0): prescaler, pwm_cnt, fade_cnt, all level[i], led_out and busy go to 0.
//  Prescaler: counts 0..CLK_DIV-1, then wraps.
//   - pwm_tick is 1 in the cycle where the prescaler = CLK_DIV-1.
//  pwm_cnt (PWM_BITS): increments on pwm_tick and wraps MAX->0.
//   - period_end = pwm_tick & (pwm_cnt==MAX).
//  fade_cnt: counts period_end events 0..FADE_PERIODS-1.
//   - fade_tick = period_end & (fade_cnt==FADE_PERIODS-1).
//  Level update, per channel i, on fade_tick only:
//   - target[i] = led_in[i] ? MAX : 0.
//   - led_in[i]=1: level = min(level+FADE_STEP, MAX); compute in PWM_BITS+1 width, then saturate.
//   - led_in[i]=0: level = max(level-FADE_STEP, 0); no underflow wrap.
//   - level == target: hold.
//  A led_in change mid-fade reverses direction at the next fade_tick, starting from the
//   current level; the level never jumps.
//  Output (registered, 1-cycle latency from the pwm_cnt/level values):
//   - led_out[i] <= (level[i]==MAX) | (level[i] > pwm_cnt).
//   - level 0 gives constant 0; MAX gives constant 1; otherwise duty = level/2**PWM_BITS.
//  busy <= OR over i of (level[i] != target[i]), registered.
//  Bypass (enable=0):
//   - led_out <= led_in, one cycle later.
//   - level[i] <= target[i] every cycle; prescaler, pwm_cnt and fade_cnt held at 0.
//   - busy <= 0.
//  Leaving bypass (enable 0->1): counters start from 0; levels already equal their targets,
//   so there is no visible glitch.
//  Reset asserted mid-fade: everything returns to 0 at once; after release all LEDs fade up
//   from 0 toward led_in.
//  led_in and enable are sampled every clk cycle; there is no handshake.
// TESTING  (bench params: NUM_LEDS=8 PWM_BITS=4 CLK_DIV=2 FADE_PERIODS=1 FADE_STEP=4)
//  1 reset: reset_n=0 with led_in=FF, enable=1 -> led_out=00 and busy=0 while in reset,
//    independent of clk.
//  2 bypass: enable=0, led_in=A5 -> led_out=A5 exactly one cycle later; busy=0;
//    pwm_cnt stays 0.
//  3 fade up: enable=1, led_in 00->01 -> level[0] reads 4,8,12,15 at successive fade_ticks
//    (every 32 clks); busy=1 until level hits 15, then 0; led_out[0] then constant 1.
//  4 duty: level[0]=4 held (led_in=01 after the first fade_tick, then force-hold)
//    -> led_out[0] high for 8 of every 32 clks.
//  5 reversal: at level[0]=8, led_in 01->00 -> next fade_ticks give 4 then 0; never wraps;
//    busy=0 at 0; led_out[0] constant 0.
//  6 reset mid-fade: level[0]=12, pulse reset_n low -> led_out=00 immediately;
//    after release with led_in=01, level[0] restarts 0->4.

Source files
------------

// File: rtl/monsopc_led_fader_if.sv
// rtl/monsopc_led_fader_if.sv - LED pattern / drive bundle between the LED PIO side and the fader
// Signals:
//   led_in   target on/off pattern (from the PIO out_port)
//   enable   1 = fade/PWM mode, 0 = bypass
//   led_out  registered drive to the physical LEDs
//   busy     1 while any channel is still fading toward its target
// Modports: master drives led_in/enable, slave (the fader) drives led_out/busy.
interface monsopc_led_fader_if #(
  parameter int NUM_LEDS = 8
);
  logic [NUM_LEDS-1:0] led_in;
  logic                enable;
  logic [NUM_LEDS-1:0] led_out;
  logic                busy;

  modport master (output led_in, output enable, input led_out, input busy);
  modport slave  (input led_in, input enable, output led_out, output busy);
endinterface

// File: rtl/monsopc_led_fader.sv
// rtl/monsopc_led_fader.sv - per-channel LED fader with shared PWM
// Ports:
//   clk      system clock (led_in is already synchronous to it)
//   reset_n  asynchronous active-low reset
//   bus      slave side of monsopc_led_fader_if: led_in, enable in; led_out, busy out
// Each channel keeps a brightness level that steps toward 0 or MAX once every
// FADE_PERIODS full PWM periods; a shared PWM counter turns the levels into duty cycles.
module monsopc_led_fader #(
  parameter int NUM_LEDS     = 8,
  parameter int PWM_BITS     = 8,
  parameter int CLK_DIV      = 4,
  parameter int FADE_PERIODS = 2,
  parameter int FADE_STEP    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  monsopc_led_fader_if.slave   bus
);

  localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FADE_W = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
  localparam logic [PWM_BITS-1:0] MAX    = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(FADE_STEP);
  localparam logic [PWM_BITS-1:0] STEP_N = PWM_BITS'(FADE_STEP);

  logic [PRE_W-1:0]    prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [FADE_W-1:0]   fade_cnt;
  logic [PWM_BITS-1:0] level      [NUM_LEDS];
  logic [PWM_BITS-1:0] level_next [NUM_LEDS];
  logic [PWM_BITS-1:0] target     [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_pwm;
  logic [NUM_LEDS-1:0] differs;
  logic [NUM_LEDS-1:0] led_out_q;
  logic                busy_q;
  logic                pwm_tick;
  logic                period_end;
  logic                fade_tick;

  assign pwm_tick   = (prescaler == PRE_W'(CLK_DIV - 1));
  assign period_end = pwm_tick & (pwm_cnt == MAX);
  assign fade_tick  = period_end & (fade_cnt == FADE_W'(FADE_PERIODS - 1));

  assign bus.led_out = led_out_q;
  assign bus.busy    = busy_q;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    logic [PWM_BITS:0] up_sum;

    assign target[i] = bus.led_in[i] ? MAX : '0;
    // Extra carry bit so an overshoot past MAX is detected rather than wrapped.
    assign up_sum    = {1'b0, level[i]} + STEP_W;
    assign level_next[i] = bus.led_in[i]
                         ? (up_sum[PWM_BITS] ? MAX : up_sum[PWM_BITS-1:0])
                         : ((level[i] > STEP_N) ? (level[i] - STEP_N) : '0);
    // MAX is forced on so full brightness has no one-count dark gap per period.
    assign led_pwm[i] = (level[i] == MAX) | (level[i] > pwm_cnt);
    assign differs[i] = (level[i] != target[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
      fade_cnt  <= '0;
      for (int i = 0; i < NUM_LEDS; i++) level[i] <= '0;
      led_out_q <= '0;
      busy_q    <= 1'b0;
    end else if (!bus.enable) begin
      // Bypass parks the counters and snaps levels to target so re-enabling
      // starts a clean period with nothing left to fade.
      prescaler <= '0;
      pwm_cnt   <= '0;
      fade_cnt  <= '0;
      for (int i = 0; i < NUM_LEDS; i++) level[i] <= target[i];
      led_out_q <= bus.led_in;
      busy_q    <= 1'b0;
    end else begin
      prescaler <= pwm_tick ? '0 : prescaler + 1'b1;
      if (pwm_tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (period_end) fade_cnt <= fade_tick ? '0 : fade_cnt + 1'b1;
      if (fade_tick) begin
        for (int i = 0; i < NUM_LEDS; i++) level[i] <= level_next[i];
      end
      led_out_q <= led_pwm;
      busy_q    <= |differs;
    end
  end

endmodule

// File: tb/tb_monsopc_led_fader.sv
// tb/tb_monsopc_led_fader.sv - self-checking bench for monsopc_led_fader
module tb_monsopc_led_fader;

  localparam int NL       = 8;
  localparam int MAXV     = 15;
  localparam int CD       = 2;
  localparam int FP       = 1;
  localparam int STEP     = 4;
  localparam int PER_CLKS = CD * (MAXV + 1);
  localparam int FADE_LEN = PER_CLKS * FP;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  monsopc_led_fader_if #(.NUM_LEDS(NL)) bus ();

  monsopc_led_fader #(
    .NUM_LEDS(NL), .PWM_BITS(4), .CLK_DIV(CD), .FADE_PERIODS(FP), .FADE_STEP(STEP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: time-since-start arithmetic gives the PWM count and the
  // fade instants; levels move by min/max clamping.
  int            t;
  int            lvl [NL];
  logic [NL-1:0] m_led_out;
  logic          m_busy;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t = 0;
      for (int i = 0; i < NL; i++) lvl[i] = 0;
      m_led_out = '0;
      m_busy = 1'b0;
    end else if (!bus.enable) begin
      t = 0;
      for (int i = 0; i < NL; i++) lvl[i] = bus.led_in[i] ? MAXV : 0;
      m_led_out = bus.led_in;
      m_busy = 1'b0;
    end else begin
      int pwm;
      logic any_diff;
      pwm = (t / CD) % (MAXV + 1);
      any_diff = 1'b0;
      for (int i = 0; i < NL; i++) begin
        m_led_out[i] = (lvl[i] == MAXV) || (lvl[i] > pwm);
        if (lvl[i] != (bus.led_in[i] ? MAXV : 0)) any_diff = 1'b1;
      end
      m_busy = any_diff;
      if (((t + 1) % FADE_LEN) == 0) begin
        for (int i = 0; i < NL; i++) begin
          if (bus.led_in[i]) lvl[i] = (lvl[i] + STEP > MAXV) ? MAXV : lvl[i] + STEP;
          else               lvl[i] = (lvl[i] - STEP < 0) ? 0 : lvl[i] - STEP;
        end
      end
      t = t + 1;
    end
  end

  // Parks in bypass with all LEDs off, then enables with the given pattern; the
  // next posedge is the first counted cycle.
  task automatic align_start(input logic [NL-1:0] pattern);
    @(posedge clk); #1;
    bus.enable = 1'b0;
    bus.led_in = '0;
    repeat (2) begin @(posedge clk); #1; end
    bus.enable = 1'b1;
    bus.led_in = pattern;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    bus.enable = 1'b1;
    bus.led_in = 8'hFF;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.led_out !== 8'h00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: led_out=%h busy=%b expected 00 0", bus.led_out, bus.busy);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (bus.led_out !== 8'h00 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: led_out=%h busy=%b expected 00 0", bus.led_out, bus.busy);
      end
    end
    @(posedge clk); #1;
    bus.enable = 1'b0;
    bus.led_in = 8'h00;
    reset_n = 1'b1;
  endtask

  task automatic test_bypass();
    repeat (3) begin @(posedge clk); #1; end
    bus.led_in = 8'hA5;
    @(negedge clk);
    checks++;
    if (bus.led_out !== 8'h00) begin
      errors++;
      $display("FAIL bypass_early: led_out=%h expected 00", bus.led_out);
    end
    @(negedge clk);
    checks++;
    if (bus.led_out !== 8'hA5 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bypass_latency: led_out=%h busy=%b expected a5 0", bus.led_out, bus.busy);
    end
  endtask

  task automatic test_fade_up();
    int exp_cnt [6] = '{0, 8, 16, 24, 32, 32};
    align_start(8'h01);
    for (int p = 0; p < 6; p++) begin
      int cnt = 0;
      for (int c = 0; c < PER_CLKS; c++) begin
        @(negedge clk);
        cnt += int'(bus.led_out[0]);
        checks++;
        if (bus.led_out !== m_led_out || bus.busy !== m_busy) begin
          errors++;
          $display("FAIL fade_up_cycle: p=%0d c=%0d led_out=%h busy=%b expected %h %b",
                   p, c, bus.led_out, bus.busy, m_led_out, m_busy);
        end
      end
      checks++;
      if (cnt != exp_cnt[p]) begin
        errors++;
        $display("FAIL fade_up_duty: period=%0d high=%0d expected %0d", p, cnt, exp_cnt[p]);
      end
      checks++;
      if (bus.busy !== (p < 4)) begin
        errors++;
        $display("FAIL fade_up_busy: period=%0d busy=%b expected %b", p, bus.busy, p < 4);
      end
    end
  endtask

  task automatic test_duty();
    int cnt = 0;
    align_start(8'h01);
    repeat (PER_CLKS) @(negedge clk);
    for (int c = 0; c < PER_CLKS; c++) begin
      @(negedge clk);
      cnt += int'(bus.led_out[0]);
    end
    checks++;
    if (cnt != 8) begin
      errors++;
      $display("FAIL duty_level4: high=%0d of 32 expected 8", cnt);
    end
  endtask

  task automatic test_reversal();
    int exp_cnt [6] = '{0, 8, 16, 8, 0, 0};
    align_start(8'h01);
    for (int p = 0; p < 6; p++) begin
      int cnt = 0;
      for (int c = 0; c < PER_CLKS; c++) begin
        @(negedge clk);
        cnt += int'(bus.led_out[0]);
        checks++;
        if (bus.led_out !== m_led_out || bus.busy !== m_busy) begin
          errors++;
          $display("FAIL reversal_cycle: p=%0d c=%0d led_out=%h busy=%b expected %h %b",
                   p, c, bus.led_out, bus.busy, m_led_out, m_busy);
        end
        if (p == 2 && c == 10) bus.led_in = 8'h00;
      end
      checks++;
      if (cnt != exp_cnt[p]) begin
        errors++;
        $display("FAIL reversal_duty: period=%0d high=%0d expected %0d", p, cnt, exp_cnt[p]);
      end
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reversal_busy: busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid_fade();
    int exp_cnt [2] = '{0, 8};
    align_start(8'h01);
    repeat (3 * PER_CLKS + 5) @(negedge clk);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.led_out !== 8'h00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midfade_reset: led_out=%h busy=%b expected 00 0", bus.led_out, bus.busy);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      int cnt = 0;
      for (int c = 0; c < PER_CLKS; c++) begin
        @(negedge clk);
        cnt += int'(bus.led_out[0]);
        checks++;
        if (bus.led_out !== m_led_out || bus.busy !== m_busy) begin
          errors++;
          $display("FAIL midfade_cycle: p=%0d c=%0d led_out=%h busy=%b expected %h %b",
                   p, c, bus.led_out, bus.busy, m_led_out, m_busy);
        end
      end
      checks++;
      if (cnt != exp_cnt[p]) begin
        errors++;
        $display("FAIL midfade_restart: period=%0d high=%0d expected %0d", p, cnt, exp_cnt[p]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 39) == 0) bus.led_in = NL'($urandom);
      if ($urandom_range(0, 299) == 0) bus.enable = ~bus.enable;
      @(negedge clk);
      checks++;
      if (bus.led_out !== m_led_out || bus.busy !== m_busy) begin
        errors++;
        $display("FAIL random_cycle: n=%0d led_in=%h en=%b led_out=%h busy=%b expected %h %b",
                 n, bus.led_in, bus.enable, bus.led_out, bus.busy, m_led_out, m_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_fade_up();
    test_duty();
    test_reversal();
    test_reset_mid_fade();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
